// File: rtl/counter_updown_mod.sv
// -----------------------------------------------------------------------------
// counter_updown_mod
// Synchronous modulo-MODULUS up/down counter with clear, saturating parallel
// load, count enable, a combinational terminal-count (cascade carry) output and
// a registered one-cycle wrap pulse. All state shares a single clock edge, so
// stages can be chained by feeding a lower stage's tc into an upper stage's en.
// -----------------------------------------------------------------------------
module counter_updown_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // -------------------------------------------------------------------------
    // Parameter legality. The upper bound is only meaningful while 2**WIDTH
    // fits in an int; for wider counters any positive int modulus fits.
    // -------------------------------------------------------------------------
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("counter_updown_mod: WIDTH must be >= 1");
        end
        if ((MODULUS < 2) || ((WIDTH < 31) && (MODULUS > (1 << WIDTH)))) begin : g_bad_modulus
            $error("counter_updown_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    // Largest legal count value, expressed in counter width.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    // When the modulus spans the whole WIDTH-bit range, every d is already
    // legal and the wrap is plain binary overflow.
    localparam bit FULL_RANGE = (WIDTH < 31) && (MODULUS == (1 << WIDTH));

    // Operation chosen at the next edge, in priority order clr > load > en.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_COUNT
    } op_e;

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    op_e              w_op;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_tc;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;

    // -------------------------------------------------------------------------
    // Terminal-count detection: tc is the "this enabled step will wrap" flag,
    // so it doubles as the carry into the next cascade stage.
    // -------------------------------------------------------------------------
    assign w_at_max  = (r_q == MAX_VAL);
    assign w_at_zero = (r_q == '0);
    assign w_tc      = en & ((up & w_at_max) | (~up & w_at_zero));

    // -------------------------------------------------------------------------
    // Load value: out-of-range requests saturate to the top of the count range
    // so q can never escape 0..MODULUS-1.
    // -------------------------------------------------------------------------
    generate
        if (FULL_RANGE) begin : g_load_full
            assign w_load_val = d;
        end else begin : g_load_sat
            assign w_load_val = (d > MAX_VAL) ? MAX_VAL : d;
        end
    endgenerate

    // Next value for one enabled count step, wrapping at either end of the range.
    always_comb begin : p_step_value
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_step_val = r_q;
        if (up) begin
            w_step_val = w_at_max ? '0 : (r_q + WIDTH'(1));
        end else begin
            w_step_val = w_at_zero ? MAX_VAL : (r_q - WIDTH'(1));
        end
    end

    // Resolve the control inputs into a single operation by priority.
    always_comb begin : p_op_select
        w_op = OP_HOLD;
        if (clr) begin
            w_op = OP_CLEAR;
        end else if (load) begin
            w_op = OP_LOAD;
        end else if (en) begin
            w_op = OP_COUNT;
        end
    end

    // Next count and next wrap flag for the selected operation.
    always_comb begin : p_next_state
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        unique case (w_op)
            OP_CLEAR: begin
                w_q_next = '0;
            end
            OP_LOAD: begin
                w_q_next = w_load_val;
            end
            OP_COUNT: begin
                w_q_next    = w_step_val;
                w_wrap_next = w_tc;
            end
            OP_HOLD: begin
                w_q_next = r_q;
            end
        endcase
    end

    // State register: asynchronous clear, all updates on the rising clock edge.
    always_ff @(posedge clk or negedge reset_n) begin : p_state_reg
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign q    = r_q;
    assign tc   = w_tc;
    assign wrap = r_wrap;

endmodule
